regfile_param: RTL and testbench
================================

# regfile_param

Parametrised successor to the processor's 2-read/1-write register file, used by the MIPS datapath decode stage. Adds configurable data width and depth, a hardwired zero register, same-cycle write-to-read bypass, a per-register pending-write scoreboard for hazard detection, and a sequential clear engine that zeroes every register after reset or on request.

## Interface
- DATA_WIDTH, 32, width of each register.
- ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH registers.
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes and pend sets.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clrReq  in  1  request to re-zero all registers.
- busy  out  1  high while the clear engine runs.
- wrEnable  in  1  write strobe.
- wrReg  in  ADDR_WIDTH  write address.
- wrData  in  DATA_WIDTH  write data.
- rdReg1 / rdReg2  in  ADDR_WIDTH  read addresses.
- rdData1 / rdData2  out  DATA_WIDTH  combinational read data.
- pendSet  in  1  mark pendReg as awaiting a write (producer issued).
- pendReg  in  ADDR_WIDTH  scoreboard address for pendSet.
- pending1 / pending2  out  1  scoreboard state of rdReg1 / rdReg2.

## Operation
- FSM states CLEAR and IDLE; 0..DEPTH-1 counter clrIdx.
- rst asserted: state=CLEAR, clrIdx=0, all scoreboard bits 0, immediately (async).
- CLEAR: each edge writes 0 to reg[clrIdx], clrIdx++; on edge writing DEPTH-1, clrIdx wraps to 0 and state->IDLE.
- IDLE: clrReq=1 at an edge -> state CLEAR, clrIdx=0, scoreboard cleared on same edge; no register written on that edge.
- clrReq while in CLEAR: ignored (no restart).
- busy = (state==CLEAR).
- While busy: wrEnable, pendSet ignored; rdData1/2 = 0; pending1/2 = 0.
- IDLE write: wrEnable=1 -> reg[wrReg] <= wrData at edge; scoreboard bit wrReg cleared at same edge.
- ZERO_REG=1: write to address 0 discarded; rdRegN==0 returns 0; pendSet to 0 ignored; pendingN for address 0 always 0.
- Read: rdDataN = reg[rdRegN]; if BYPASS=1 and wrEnable and wrReg==rdRegN (and not the zero register) then rdDataN = wrData.
- pendSet=1 (IDLE): bit pendReg set at edge.
- Same edge pendSet and wrEnable to same address: set wins (bit ends 1; data still written).
- pendingN = pend[rdRegN], forced 0 if BYPASS=1 and a write to rdRegN is present this cycle.
- Both read ports independent; rdReg1==rdReg2 returns identical data.

## Timing
- Reset values: busy=1, rdData1/2=0, pending1/2=0.
- After rst deasserts, busy stays 1 for exactly DEPTH rising edges (32 for defaults); first IDLE cycle follows.
- clrReq-triggered clear: busy rises after the requesting edge, 1 cycle entry + DEPTH clear cycles.
- Write latency: visible on read ports in the cycle after the edge; same cycle when BYPASS=1.
- Scoreboard set/clear take effect one edge after pendSet/wrEnable.
- rst mid-clear: clear restarts from clrIdx=0; mid-IDLE: register contents undefined until re-zeroed by the clear.
- No combinational path from clrReq or pendSet to any output.

## Test plan
- Reset, release, hold clk: busy=1 for 32 edges then 0; reads of every register return 0; pending all 0.
- Write reg i = 2*i for i=0..31, then read pairs (0,1)…(30,31): rdData=2*i except reg0=0.
- BYPASS=1: wrEnable=1, wrReg=7, wrData=0xDEADBEEF, rdReg1=7 same cycle -> rdData1=0xDEADBEEF; BYPASS=0 -> old value until next cycle.
- pendSet reg 5, next cycle pending1=1 with rdReg1=5; write reg 5 -> pending1=0 in that cycle (bypass) and after edge; simultaneous pendSet+write reg 5 -> pending stays 1.
- With registers loaded, pulse clrReq: busy high 33 cycles, writes during busy ignored, afterwards all reads 0; clrReq during busy does not extend it.
- Assert rst at clear index 10: busy stays 1 and full 32-cycle clear repeats; DATA_WIDTH=16, ADDR_WIDTH=3 variant: busy 8 cycles, 16-bit data round-trips.

Source files
------------

// File: rtl/regfile_param.sv
// ============================================================================
// Module   : regfile_param
// Brief    : 2-read/1-write register file with bypass, scoreboard, clear engine
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clrReq,
    output logic                  busy,
    input  logic                  wrEnable,
    input  logic [ADDR_WIDTH-1:0] wrReg,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic [ADDR_WIDTH-1:0] rdReg1,
    input  logic [ADDR_WIDTH-1:0] rdReg2,
    output logic [DATA_WIDTH-1:0] rdData1,
    output logic [DATA_WIDTH-1:0] rdData2,
    input  logic                  pendSet,
    input  logic [ADDR_WIDTH-1:0] pendReg,
    output logic                  pending1,
    output logic                  pending2
);

    localparam int                    DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ONE   = ADDR_WIDTH'(1);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_clr_idx;
    logic [DEPTH-1:0]        r_pend;
    logic [DATA_WIDTH-1:0]   r_regs [DEPTH];

    logic w_busy;
    logic w_wr_ok;
    logic w_pend_ok;

    function automatic logic f_is_zero(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign w_busy    = (r_state == S_CLEAR);
    assign w_wr_ok   = wrEnable && !w_busy && !f_is_zero(wrReg);
    assign w_pend_ok = pendSet  && !w_busy && !f_is_zero(pendReg);
    assign busy      = w_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
            r_pend    <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_pend    <= '0;
                    r_clr_idx <= r_clr_idx + c_ONE;
                    if (r_clr_idx == c_LAST) begin
                        r_clr_idx <= '0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    if (clrReq) begin
                        r_state   <= S_CLEAR;
                        r_clr_idx <= '0;
                        r_pend    <= '0;
                    end else begin
                        // Set is applied after clear so a simultaneous set wins.
                        if (w_wr_ok)   r_pend[wrReg]   <= 1'b0;
                        if (w_pend_ok) r_pend[pendReg] <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Storage is not reset; the clear engine zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_regs[r_clr_idx] <= '0;
        end else if (w_wr_ok && !clrReq) begin
            r_regs[wrReg] <= wrData;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_addr;
        logic                  w_hit;
        logic [DATA_WIDTH-1:0] w_data;
        logic                  w_pnd;

        assign w_addr = (p == 0) ? rdReg1 : rdReg2;
        assign w_hit  = (BYPASS != 0) && wrEnable && (wrReg == w_addr);

        always_comb begin
            w_data = '0;
            w_pnd  = 1'b0;
            if (!w_busy && !f_is_zero(w_addr)) begin
                w_data = w_hit ? wrData : r_regs[w_addr];
                w_pnd  = w_hit ? 1'b0   : r_pend[w_addr];
            end
        end
    end

    assign rdData1  = g_rd[0].w_data;
    assign rdData2  = g_rd[1].w_data;
    assign pending1 = g_rd[0].w_pnd;
    assign pending2 = g_rd[1].w_pnd;

endmodule

`default_nettype wire

// File: tb/tb_regfile_param.sv
// ============================================================================
// Module   : tb_regfile_param
// Brief    : Directed table-driven bench for regfile_param (default + small variant)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance: 32x32, zero register, bypass
    logic        rst, clrReq, wrEnable, pendSet;
    logic [4:0]  wrReg, rdReg1, rdReg2, pendReg;
    logic [31:0] wrData;
    logic        busy, pending1, pending2;
    logic [31:0] rdData1, rdData2;

    // Small instance: 8x16, no zero register, no bypass
    logic        rst_b, clrReq_b, wrEnable_b, pendSet_b;
    logic [2:0]  wrReg_b, rdReg1_b, rdReg2_b, pendReg_b;
    logic [15:0] wrData_b;
    logic        busy_b, pending1_b, pending2_b;
    logic [15:0] rdData1_b, rdData2_b;

    regfile_param u_dut (
        .clk(clk), .rst(rst), .clrReq(clrReq), .busy(busy),
        .wrEnable(wrEnable), .wrReg(wrReg), .wrData(wrData),
        .rdReg1(rdReg1), .rdReg2(rdReg2), .rdData1(rdData1), .rdData2(rdData2),
        .pendSet(pendSet), .pendReg(pendReg), .pending1(pending1), .pending2(pending2)
    );

    regfile_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst(rst_b), .clrReq(clrReq_b), .busy(busy_b),
        .wrEnable(wrEnable_b), .wrReg(wrReg_b), .wrData(wrData_b),
        .rdReg1(rdReg1_b), .rdReg2(rdReg2_b), .rdData1(rdData1_b), .rdData2(rdData2_b),
        .pendSet(pendSet_b), .pendReg(pendReg_b), .pending1(pending1_b), .pending2(pending2_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        clrReq = 0; wrEnable = 0; wrReg = 0; wrData = 0;
        rdReg1 = 0; rdReg2 = 0; pendSet = 0; pendReg = 0;
    endtask

    task automatic read_all_a(input string tag, input logic use_model);
        for (int k = 0; k < 16; k++) begin
            rdReg1 = 5'(2 * k);
            rdReg2 = 5'(2 * k + 1);
            #1;
            chk({tag, "_d1"}, rdData1, use_model ? ((k == 0) ? 32'd0 : 32'(4 * k)) : 32'd0);
            chk({tag, "_d2"}, rdData2, use_model ? 32'(4 * k + 2) : 32'd0);
            chk({tag, "_p1"}, {31'd0, pending1}, 32'd0);
            chk({tag, "_p2"}, {31'd0, pending2}, 32'd0);
        end
    endtask

    task automatic count_busy_a(input int start, output int n);
        n = start;
        while (busy && n < 100) begin
            step();
            n++;
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        ps;
        logic [4:0]  pr;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        ep1;
        logic        ep2;
    } vec_t;

    vec_t tv [14];

    initial begin
        int n;

        // Registers hold 2*i when this table runs.
        tv[0]  = '{1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd8, 1'b0, 5'd0, 32'hDEADBEEF, 32'd16, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 1'b0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
        tv[2]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd6, 1'b1, 5'd5, 32'd10, 32'd12, 1'b0, 1'b0};
        tv[3]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b0, 5'd0, 32'd10, 32'd0,  1'b1, 1'b0};
        tv[4]  = '{1'b1, 5'd5, 32'h55,       5'd5, 5'd5, 1'b0, 5'd0, 32'h55, 32'h55, 1'b0, 1'b0};
        tv[5]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd3, 1'b0, 5'd0, 32'h55, 32'd6,  1'b0, 1'b0};
        tv[6]  = '{1'b1, 5'd5, 32'h66,       5'd5, 5'd3, 1'b1, 5'd5, 32'h66, 32'd6,  1'b0, 1'b0};
        tv[7]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 1'b0, 5'd0, 32'h66, 32'h66, 1'b1, 1'b1};
        tv[8]  = '{1'b1, 5'd0, 32'h1234,     5'd0, 5'd1, 1'b1, 5'd0, 32'd0,  32'd2,  1'b0, 1'b0};
        tv[9]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b0, 5'd0, 32'd0,  32'd0,  1'b0, 1'b0};
        tv[10] = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd9, 1'b1, 5'd9, 32'd18, 32'd18, 1'b0, 1'b0};
        tv[11] = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd5, 1'b0, 5'd0, 32'd18, 32'h66, 1'b1, 1'b1};
        tv[12] = '{1'b1, 5'd9, 32'hA,        5'd1, 5'd9, 1'b0, 5'd0, 32'd2,  32'hA,  1'b0, 1'b0};
        tv[13] = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd5, 1'b0, 5'd0, 32'hA,  32'h66, 1'b0, 1'b1};

        idle_a();
        rst = 1;
        rst_b = 1; clrReq_b = 0; wrEnable_b = 0; wrReg_b = 0; wrData_b = 0;
        rdReg1_b = 0; rdReg2_b = 0; pendSet_b = 0; pendReg_b = 0;
        rdReg1 = 3; rdReg2 = 4;
        repeat (3) step();
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_d1", rdData1, 32'd0);
        chk("rst_d2", rdData2, 32'd0);
        chk("rst_p1", {31'd0, pending1}, 32'd0);
        chk("rst_busy_b", {31'd0, busy_b}, 32'd1);

        rst = 0;
        count_busy_a(0, n);
        chk("reset_busy_edges", 32'(n), 32'd32);
        read_all_a("post_reset", 1'b0);

        for (int i = 0; i < 32; i++) begin
            wrEnable = 1; wrReg = 5'(i); wrData = 32'(2 * i);
            step();
        end
        idle_a();
        read_all_a("load", 1'b1);

        for (int t = 0; t < 14; t++) begin
            wrEnable = tv[t].we; wrReg = tv[t].wr; wrData = tv[t].wd;
            rdReg1 = tv[t].r1; rdReg2 = tv[t].r2; pendSet = tv[t].ps; pendReg = tv[t].pr;
            #1;
            chk($sformatf("vec%0d_d1", t), rdData1, tv[t].e1);
            chk($sformatf("vec%0d_d2", t), rdData2, tv[t].e2);
            chk($sformatf("vec%0d_p1", t), {31'd0, pending1}, {31'd0, tv[t].ep1});
            chk($sformatf("vec%0d_p2", t), {31'd0, pending2}, {31'd0, tv[t].ep2});
            step();
        end
        idle_a();

        // Clear request: write on the request edge and writes/pends during busy are dropped.
        clrReq = 1; wrEnable = 1; wrReg = 3; wrData = 32'h77;
        #1;
        chk("clr_req_busy_before", {31'd0, busy}, 32'd0);
        step();
        chk("clr_busy_after_req", {31'd0, busy}, 32'd1);
        wrReg = 4; wrData = 32'hFF; pendSet = 1; pendReg = 4; rdReg1 = 2; rdReg2 = 4;
        #1;
        chk("clr_busy_d1", rdData1, 32'd0);
        chk("clr_busy_p2", {31'd0, pending2}, 32'd0);
        n = 1;
        while (busy && n < 100) begin
            if (n == 5) clrReq = 0;
            step();
            n++;
        end
        chk("clr_edges_to_idle", 32'(n), 32'd33);
        idle_a();
        read_all_a("post_clr", 1'b0);

        // Reset asserted mid-clear at index 10 restarts the full clear.
        clrReq = 1;
        step();
        clrReq = 0;
        repeat (10) step();
        chk("midclr_busy", {31'd0, busy}, 32'd1);
        rst = 1;
        #1;
        chk("midclr_rst_busy", {31'd0, busy}, 32'd1);
        step();
        rst = 0;
        count_busy_a(0, n);
        chk("midclr_restart_edges", 32'(n), 32'd32);
        wrEnable = 1; wrReg = 12; wrData = 32'h1;
        step();
        wrEnable = 0; rdReg1 = 12;
        #1;
        chk("midclr_write_after", rdData1, 32'h1);
        idle_a();

        // Small variant: 8 entries, 16-bit, no bypass, register 0 writable.
        rst_b = 0;
        n = 0;
        while (busy_b && n < 100) begin
            step();
            n++;
        end
        chk("b_reset_busy_edges", 32'(n), 32'd8);
        wrEnable_b = 1; wrReg_b = 0; wrData_b = 16'hBEEF; rdReg1_b = 0;
        #1;
        chk("b_nobypass_r0", {16'd0, rdData1_b}, 32'd0);
        step();
        wrReg_b = 7; wrData_b = 16'hA5A5;
        #1;
        chk("b_r0_written", {16'd0, rdData1_b}, 32'hBEEF);
        step();
        wrData_b = 16'h1234; rdReg1_b = 7; rdReg2_b = 7;
        #1;
        chk("b_old_value", {16'd0, rdData1_b}, 32'hA5A5);
        step();
        wrEnable_b = 0;
        #1;
        chk("b_new_d1", {16'd0, rdData1_b}, 32'h1234);
        chk("b_new_d2", {16'd0, rdData2_b}, 32'h1234);
        pendSet_b = 1; pendReg_b = 3;
        step();
        pendSet_b = 0; wrEnable_b = 1; wrReg_b = 3; wrData_b = 16'h3333; rdReg1_b = 3;
        #1;
        chk("b_pend_no_bypass", {31'd0, pending1_b}, 32'd1);
        chk("b_d_no_bypass", {16'd0, rdData1_b}, 32'd0);
        step();
        wrEnable_b = 0;
        #1;
        chk("b_pend_cleared", {31'd0, pending1_b}, 32'd0);
        chk("b_d_written", {16'd0, rdData1_b}, 32'h3333);
        pendSet_b = 1; pendReg_b = 0;
        step();
        pendSet_b = 0; rdReg1_b = 0;
        #1;
        chk("b_pend_r0", {31'd0, pending1_b}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
